// File: rtl/edge_mask_writer.sv
// edge_mask_writer
// Command-driven builder/launcher for the route-planner graph-search engine.
// Maintains a symmetric NODES x NODES adjacency bitmap from ADD/DEL/CLEAR
// commands, then launches a search on RUN and freezes its outputs until the
// engine reports completion.
//
// Ports:
//   CLK, RST_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake; ready is high only in IDLE
//   cmd_op            0=ADD 1=DEL 2=CLEAR 3=RUN
//   cmd_a, cmd_b      node pair (ADD/DEL) or start/end node (RUN)
//   edgeMask          bit {i,j} set = edge i->j
//   startPoint/endpoint latched search endpoints
//   search_start      one-cycle launch pulse (registered)
//   search_done       one-cycle completion pulse from the engine
//   busy              high whenever not IDLE
//   err               one-cycle pulse the cycle after a rejected command
module edge_mask_writer #(
    parameter int NODES = 32,
    parameter int IDXW  = 8
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [IDXW-1:0]        cmd_a,
    input  logic [IDXW-1:0]        cmd_b,
    output logic [NODES*NODES-1:0] edgeMask,
    output logic [IDXW-1:0]        startPoint,
    output logic [IDXW-1:0]        endpoint,
    output logic                   search_start,
    input  logic                   search_done,
    output logic                   busy,
    output logic                   err
);
    localparam int NW = $clog2(NODES);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_DEL = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;
    localparam logic [1:0] OP_RUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_AB, S_WR_BA, S_CLR, S_LAUNCH, S_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [NODES*NODES-1:0]   mask_q, mask_d;
    logic [NW-1:0]            a_q, a_d, b_q, b_d, row_q, row_d;
    logic                     set_q, set_d;
    logic [IDXW-1:0]          sp_q, sp_d, ep_q, ep_d;
    logic                     ss_q, ss_d, err_q, err_d;
    logic                     idx_bad;

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign edgeMask     = mask_q;
    assign startPoint   = sp_q;
    assign endpoint     = ep_q;
    assign search_start = ss_q;
    assign err          = err_q;

    assign idx_bad = (cmd_a >= IDXW'(NODES)) || (cmd_b >= IDXW'(NODES));

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        a_d     = a_q;
        b_d     = b_q;
        set_d   = set_q;
        row_d   = row_q;
        sp_d    = sp_q;
        ep_d    = ep_q;
        ss_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_ADD, OP_DEL: begin
                            if (idx_bad) begin
                                err_d = 1'b1;
                            end else begin
                                a_d     = cmd_a[NW-1:0];
                                b_d     = cmd_b[NW-1:0];
                                set_d   = (cmd_op == OP_ADD);
                                state_d = S_WR_AB;
                            end
                        end
                        OP_CLR: begin
                            row_d   = '0;
                            state_d = S_CLR;
                        end
                        default: begin // OP_RUN
                            if (idx_bad) begin
                                err_d = 1'b1;
                            end else begin
                                sp_d    = cmd_a;
                                ep_d    = cmd_b;
                                // Registered pulse: high for the LAUNCH cycle.
                                ss_d    = 1'b1;
                                state_d = S_LAUNCH;
                            end
                        end
                    endcase
                end
            end
            S_WR_AB: begin
                mask_d[{a_q, b_q}] = set_q;
                // Self-loop has only one bit to write.
                state_d = (a_q == b_q) ? S_IDLE : S_WR_BA;
            end
            S_WR_BA: begin
                mask_d[{b_q, a_q}] = set_q;
                state_d = S_IDLE;
            end
            S_CLR: begin
                mask_d[{row_q, {NW{1'b0}}} +: NODES] = '0;
                if (row_q == NW'(NODES - 1)) begin
                    row_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            // A done pulse coinciding with the launch belongs to a previous
            // search, so LAUNCH always proceeds to WAIT.
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (search_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            set_q   <= 1'b0;
            row_q   <= '0;
            sp_q    <= '0;
            ep_q    <= '0;
            ss_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            a_q     <= a_d;
            b_q     <= b_d;
            set_q   <= set_d;
            row_q   <= row_d;
            sp_q    <= sp_d;
            ep_q    <= ep_d;
            ss_q    <= ss_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_edge_mask_writer.sv
module tb_edge_mask_writer;
    logic          CLK = 1'b0, RST_n = 1'b0, cmd_valid = 1'b0, search_done = 1'b0;
    logic [1:0]    cmd_op = 2'd0;
    logic [7:0]    cmd_a = 8'd0, cmd_b = 8'd0;
    logic          cmd_ready, search_start, busy, err;
    logic [1023:0] edgeMask;
    logic [7:0]    startPoint, endpoint;

    edge_mask_writer #(.NODES(32), .IDXW(8)) dut (
        .CLK(CLK), .RST_n(RST_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .edgeMask(edgeMask),
        .startPoint(startPoint), .endpoint(endpoint), .search_start(search_start),
        .search_done(search_done), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string         name;
        logic [1023:0] mask;
        int            len;   // -1: busy length not checked
        int            ss;
        int            sp, ep;
    } rec_t;

    rec_t          txq[$];
    logic [1023:0] errq[$];
    int            n_cmp = 0, n_bad = 0;
    logic [1023:0] exp_mask = '0;

    function automatic void chk_int(string nm, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endfunction

    function automatic void chk_mask(string nm, logic [1023:0] act, logic [1023:0] req);
        int first, ndiff;
        first = -1; ndiff = 0;
        n_cmp++;
        for (int i = 0; i < 1024; i++) begin
            if (act[i] !== req[i]) begin
                ndiff++;
                if (first < 0) first = i;
            end
        end
        if (ndiff != 0) begin
            n_bad++;
            $display("FAIL %s: edgeMask bit %0d actual %b required %b (%0d bits differ)",
                     nm, first, act[first], req[first], ndiff);
        end
    endfunction

    // Monitor: end of each busy period and each err pulse pop an expectation.
    initial begin
        logic          prev_busy;
        int            len, ssc;
        rec_t          r;
        logic [1023:0] m;
        prev_busy = 1'b0; len = 0; ssc = 0;
        forever begin
            @(negedge CLK);
            if (err === 1'b1) begin
                if (errq.size() == 0) chk_int("unexpected err pulse", 1, 0);
                else begin
                    m = errq.pop_front();
                    chk_mask("mask at err", edgeMask, m);
                end
            end
            if (busy === 1'b1) begin
                if (!prev_busy) begin len = 0; ssc = 0; end
                len++;
                if (search_start === 1'b1) ssc++;
            end else if (prev_busy) begin
                if (txq.size() == 0) chk_int("unexpected busy period", 1, 0);
                else begin
                    r = txq.pop_front();
                    chk_mask(r.name, edgeMask, r.mask);
                    if (r.len >= 0) chk_int({r.name, " busy cycles"}, len, r.len);
                    chk_int({r.name, " search_start cycles"}, ssc, r.ss);
                    chk_int({r.name, " startPoint"}, int'(startPoint), r.sp);
                    chk_int({r.name, " endpoint"}, int'(endpoint), r.ep);
                end
            end
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic send(input logic [1:0] op, input int a, input int b);
        int t;
        @(negedge CLK);
        cmd_op = op; cmd_a = 8'(a); cmd_b = 8'(b); cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 200) begin @(negedge CLK); t++; end
        if (t >= 200) chk_int("accept timeout", 0, 1);
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
    endtask

    // Expected values for ADD/DEL come from the bench's own mask model.
    task automatic push_edge(input logic [1:0] op, input int a, input int b, input int sp, input int ep);
        rec_t r;
        exp_mask[a*32+b] = (op == 2'd0);
        exp_mask[b*32+a] = (op == 2'd0);
        r.name = $sformatf("%s %0d,%0d", (op == 2'd0) ? "ADD" : "DEL", a, b);
        r.mask = exp_mask; r.len = (a == b) ? 1 : 2; r.ss = 0; r.sp = sp; r.ep = ep;
        txq.push_back(r);
    endtask

    task automatic edge_cmd(input logic [1:0] op, input int a, input int b);
        push_edge(op, a, b, 0, 0);
        send(op, a, b);
    endtask

    initial begin
        int   ea[20], eb[20], ssn;
        rec_t r;
        ea = '{0, 1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 22, 24, 26, 28, 30, 31, 9, 17};
        eb = '{31, 2, 30, 4, 11, 13, 15, 17, 19, 21, 23, 25, 27, 29, 1, 3, 5, 31, 9, 0};

        // Reset state
        repeat (2) @(negedge CLK);
        chk_int("reset cmd_ready", int'(cmd_ready), 1);
        chk_int("reset busy", int'(busy), 0);
        chk_int("reset err", int'(err), 0);
        chk_int("reset search_start", int'(search_start), 0);
        chk_mask("reset edgeMask", edgeMask, '0);
        #2 RST_n = 1'b1;

        // ADD 3,7 -> bits 103 and 227
        edge_cmd(2'd0, 3, 7);
        repeat (3) @(negedge CLK);
        chk_int("bit 103 after ADD 3,7", int'(edgeMask[103]), 1);
        chk_int("bit 227 after ADD 3,7", int'(edgeMask[227]), 1);
        chk_int("popcount after ADD 3,7", $countones(edgeMask), 2);

        // Self-loop then delete
        edge_cmd(2'd0, 5, 5);
        edge_cmd(2'd1, 3, 7);
        repeat (3) @(negedge CLK);
        chk_int("bit 165 after ADD 5,5", int'(edgeMask[165]), 1);
        chk_int("popcount after DEL 3,7", $countones(edgeMask), 1);

        // Out-of-range ADD: err pulse, mask unchanged, no busy
        errq.push_back(exp_mask);
        send(2'd0, 40, 2);
        @(negedge CLK);
        chk_int("cmd_ready after rejected ADD", int'(cmd_ready), 1);
        @(negedge CLK);
        chk_int("err after pulse", int'(err), 0);

        // Twenty edges, then CLEAR (32 busy cycles)
        for (int i = 0; i < 20; i++) edge_cmd(2'd0, ea[i], eb[i]);
        exp_mask = '0;
        r.name = "CLEAR"; r.mask = '0; r.len = 32; r.ss = 0; r.sp = 0; r.ep = 0;
        txq.push_back(r);
        send(2'd2, 0, 0);

        // A few edges so the freeze and the reset clear are observable
        edge_cmd(2'd0, 1, 2);
        edge_cmd(2'd0, 30, 31);

        // RUN 0,31 with an ADD held during WAIT, done after 50 cycles
        r.name = "RUN 0,31"; r.mask = exp_mask; r.len = 50; r.ss = 1; r.sp = 0; r.ep = 31;
        txq.push_back(r);
        push_edge(2'd0, 9, 10, 0, 31);
        send(2'd3, 0, 31);
        cmd_op = 2'd0; cmd_a = 8'd9; cmd_b = 8'd10; cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                chk_int("RUN 0,31 startPoint", int'(startPoint), 0);
                chk_int("RUN 0,31 endpoint", int'(endpoint), 31);
            end
        end
        search_done = 1'b1;
        @(posedge CLK);
        #1 search_done = 1'b0;
        @(negedge CLK);
        chk_int("held ADD seen by IDLE", int'(cmd_ready), 1);
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge CLK);

        // RUN 1,2, done pulse during LAUNCH is ignored, reset during WAIT
        r.name = "RUN 1,2 reset"; r.mask = '0; r.len = -1; r.ss = 1; r.sp = 0; r.ep = 0;
        txq.push_back(r);
        send(2'd3, 1, 2);
        search_done = 1'b1;
        @(posedge CLK);
        #1 search_done = 1'b0;
        repeat (5) @(negedge CLK);
        chk_int("still busy after done in LAUNCH", int'(busy), 1);
        chk_int("RUN 1,2 startPoint", int'(startPoint), 1);
        chk_int("RUN 1,2 endpoint", int'(endpoint), 2);
        #2 RST_n = 1'b0;
        #1;
        chk_mask("async reset edgeMask", edgeMask, '0);
        chk_int("async reset startPoint", int'(startPoint), 0);
        chk_int("async reset endpoint", int'(endpoint), 0);
        chk_int("async reset cmd_ready", int'(cmd_ready), 1);
        chk_int("async reset busy", int'(busy), 0);
        exp_mask = '0;
        @(negedge CLK);
        #2 RST_n = 1'b1;
        ssn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (search_start === 1'b1) ssn++;
        end
        chk_int("search_start after reset release", ssn, 0);
        chk_int("cmd_ready after reset release", int'(cmd_ready), 1);

        chk_int("busy expectations left", txq.size(), 0);
        chk_int("err expectations left", errq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
